// File: rtl/alu_issue_pkg.sv
// Shared types and sizes for the ALU issue stage.
// ALU_ISSUE_FWD_EN enables writeback-to-operand forwarding in alu_issue.
package alu_issue_pkg;

  localparam int unsigned NREGS  = 16;
  localparam int unsigned RIDX_W = $clog2(NREGS);
  localparam int unsigned DATA_W = 64;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_ADC  = 4'd2,
    OP_SBB  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_CMP  = 4'd7,
    OP_TEST = 4'd8,
    OP_SHL  = 4'd9,
    OP_SHR  = 4'd10,
    OP_SAR  = 4'd11,
    OP_MOV  = 4'd12
  } opcode_t;

  typedef struct packed {
    opcode_t             opcode;
    logic [RIDX_W-1:0]   dst;
    logic [RIDX_W-1:0]   src1;
    logic [RIDX_W-1:0]   src2;
    logic [DATA_W-1:0]   imm;
    logic                use_imm;
    logic                rd_flags;
    logic                wr_flags;
  } uop_t;

  // Resolved form of a uop as presented to the ALU.
  typedef struct packed {
    opcode_t             opcode;
    logic [DATA_W-1:0]   op1;
    logic [DATA_W-1:0]   op2;
    logic [RIDX_W-1:0]   dst;
    logic                wr_flags;
  } aluop_t;

  function automatic logic touches_flags(uop_t u);
    return u.rd_flags | u.wr_flags;
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Decode, register-file, ALU and writeback signals of the issue stage.
// slave = issue stage side, master = surrounding pipeline.
interface alu_issue_if;
  import alu_issue_pkg::*;

  logic                in_valid;
  logic                in_ready;
  opcode_t             in_opcode;
  logic [RIDX_W-1:0]   in_dst;
  logic [RIDX_W-1:0]   in_src1;
  logic [RIDX_W-1:0]   in_src2;
  logic [DATA_W-1:0]   in_imm;
  logic                in_use_imm;
  logic                in_rd_flags;
  logic                in_wr_flags;

  logic [RIDX_W-1:0]   rf_raddr1;
  logic [RIDX_W-1:0]   rf_raddr2;
  logic [DATA_W-1:0]   rf_rdata1;
  logic [DATA_W-1:0]   rf_rdata2;

  logic                alu_valid;
  logic                alu_ready;
  opcode_t             alu_opcode;
  logic [DATA_W-1:0]   alu_operand1;
  logic [DATA_W-1:0]   alu_operand2;
  logic [RIDX_W-1:0]   alu_dst;
  logic                alu_wr_flags;

  logic                wb_valid;
  logic [RIDX_W-1:0]   wb_dst;
  logic [DATA_W-1:0]   wb_data;
  logic                wb_flags;

  modport slave (
    input  in_valid, in_opcode, in_dst, in_src1, in_src2, in_imm,
           in_use_imm, in_rd_flags, in_wr_flags,
    output in_ready,
    output rf_raddr1, rf_raddr2,
    input  rf_rdata1, rf_rdata2,
    output alu_valid, alu_opcode, alu_operand1, alu_operand2, alu_dst,
           alu_wr_flags,
    input  alu_ready,
    input  wb_valid, wb_dst, wb_data, wb_flags
  );

  modport master (
    output in_valid, in_opcode, in_dst, in_src1, in_src2, in_imm,
           in_use_imm, in_rd_flags, in_wr_flags,
    input  in_ready,
    input  rf_raddr1, rf_raddr2,
    output rf_rdata1, rf_rdata2,
    input  alu_valid, alu_opcode, alu_operand1, alu_operand2, alu_dst,
           alu_wr_flags,
    output alu_ready,
    output wb_valid, wb_dst, wb_data, wb_flags
  );

endinterface

// File: rtl/alu_issue_scoreboard.sv
// Per-register busy bits plus an RFLAGS busy bit.
// A set and a clear of the same entry in one cycle leaves it set.
module alu_issue_scoreboard
  import alu_issue_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              set_en_i,
  input  logic [RIDX_W-1:0] set_idx_i,
  input  logic              set_flags_i,
  input  logic              clr_en_i,
  input  logic [RIDX_W-1:0] clr_idx_i,
  input  logic              clr_flags_i,
  input  logic [RIDX_W-1:0] q_src1_i,
  input  logic [RIDX_W-1:0] q_src2_i,
  input  logic [RIDX_W-1:0] q_dst_i,
  output logic              busy_src1_o,
  output logic              busy_src2_o,
  output logic              busy_dst_o,
  output logic              fbusy_o
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic             fbusy_q, fbusy_d;

  always_comb begin
    busy_d  = busy_q;
    fbusy_d = fbusy_q;
    if (clr_en_i)    busy_d[clr_idx_i] = 1'b0;
    if (set_en_i)    busy_d[set_idx_i] = 1'b1;
    if (clr_flags_i) fbusy_d = 1'b0;
    if (set_flags_i) fbusy_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q  <= '0;
      fbusy_q <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      fbusy_q <= fbusy_d;
    end
  end

  always_comb begin
    busy_src1_o = busy_q[q_src1_i];
    busy_src2_o = busy_q[q_src2_i];
    busy_dst_o  = busy_q[q_dst_i];
    fbusy_o     = fbusy_q;
  end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: capture register, hazard check, operand read, output register.
// ALU_ISSUE_FWD_EN forwards same-cycle writebacks into hazard and operand select.
module alu_issue
  import alu_issue_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  alu_issue_if.slave bus
);

  uop_t              cap_q, cap_d, in_uop;
  logic              cap_v_q, cap_v_d;
  aluop_t            out_q, out_d;
  logic              out_v_q, out_v_d;
  logic              busy_s1, busy_s2, busy_dst, fbusy;
  logic              clr_s1, clr_s2, clr_dst, clr_f;
  logic [DATA_W-1:0] op1, op2;
  logic              hazard, move, ready, accept;

  always_comb begin
    in_uop = '{opcode:   bus.in_opcode,
               dst:      bus.in_dst,
               src1:     bus.in_src1,
               src2:     bus.in_src2,
               imm:      bus.in_imm,
               use_imm:  bus.in_use_imm,
               rd_flags: bus.in_rd_flags,
               wr_flags: bus.in_wr_flags};
  end

`ifdef ALU_ISSUE_FWD_EN
  always_comb begin
    clr_s1  = bus.wb_valid && (bus.wb_dst == cap_q.src1);
    clr_s2  = bus.wb_valid && (bus.wb_dst == cap_q.src2);
    clr_dst = bus.wb_valid && (bus.wb_dst == cap_q.dst);
    clr_f   = bus.wb_valid && bus.wb_flags;
    op1     = clr_s1 ? bus.wb_data : bus.rf_rdata1;
    op2     = cap_q.use_imm ? cap_q.imm : (clr_s2 ? bus.wb_data : bus.rf_rdata2);
  end
`else
  // Without forwarding the uop waits for the scoreboard bit to clear
  // and picks the value up from the register file on the next cycle.
  always_comb begin
    clr_s1  = 1'b0;
    clr_s2  = 1'b0;
    clr_dst = 1'b0;
    clr_f   = 1'b0;
    op1     = bus.rf_rdata1;
    op2     = cap_q.use_imm ? cap_q.imm : bus.rf_rdata2;
  end
`endif

  always_comb begin
    hazard = (busy_s1 && !clr_s1)
          || (!cap_q.use_imm && busy_s2 && !clr_s2)
          || (busy_dst && !clr_dst)
          || (touches_flags(cap_q) && fbusy && !clr_f);
    move   = cap_v_q && !hazard && (!out_v_q || bus.alu_ready);
    ready  = !reset && (!cap_v_q || move);
    accept = bus.in_valid && ready;
  end

  alu_issue_scoreboard u_sb (
    .clk_i       (clk),
    .rst_i       (reset),
    .set_en_i    (move),
    .set_idx_i   (cap_q.dst),
    .set_flags_i (move && cap_q.wr_flags),
    .clr_en_i    (bus.wb_valid),
    .clr_idx_i   (bus.wb_dst),
    .clr_flags_i (bus.wb_valid && bus.wb_flags),
    .q_src1_i    (cap_q.src1),
    .q_src2_i    (cap_q.src2),
    .q_dst_i     (cap_q.dst),
    .busy_src1_o (busy_s1),
    .busy_src2_o (busy_s2),
    .busy_dst_o  (busy_dst),
    .fbusy_o     (fbusy)
  );

  always_comb begin
    cap_d   = cap_q;
    cap_v_d = cap_v_q;
    out_d   = out_q;
    out_v_d = out_v_q;
    if (accept) begin
      cap_d   = in_uop;
      cap_v_d = 1'b1;
    end else if (move) begin
      cap_v_d = 1'b0;
    end
    if (move) begin
      out_d   = '{opcode: cap_q.opcode, op1: op1, op2: op2,
                  dst: cap_q.dst, wr_flags: cap_q.wr_flags};
      out_v_d = 1'b1;
    end else if (bus.alu_ready) begin
      out_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_q   <= '0;
      cap_v_q <= 1'b0;
      out_q   <= '0;
      out_v_q <= 1'b0;
    end else begin
      cap_q   <= cap_d;
      cap_v_q <= cap_v_d;
      out_q   <= out_d;
      out_v_q <= out_v_d;
    end
  end

  always_comb begin
    bus.in_ready     = ready;
    bus.rf_raddr1    = cap_v_q ? cap_q.src1 : '0;
    bus.rf_raddr2    = cap_v_q ? cap_q.src2 : '0;
    bus.alu_valid    = out_v_q;
    bus.alu_opcode   = out_q.opcode;
    bus.alu_operand1 = out_q.op1;
    bus.alu_operand2 = out_q.op2;
    bus.alu_dst      = out_q.dst;
    bus.alu_wr_flags = out_q.wr_flags;
  end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: vector table for flow/backpressure, hand sequences for hazards and reset.
module tb_alu_issue;
  import alu_issue_pkg::*;

`ifdef ALU_ISSUE_FWD_EN
  localparam logic FWD = 1'b1;
`else
  localparam logic FWD = 1'b0;
`endif

  typedef struct {
    logic        iv;
    opcode_t     op;
    logic [3:0]  dst, s1, s2;
    logic        ui;
    logic [63:0] imm;
    logic        ar;
    logic        e_ir, e_av;
    logic [63:0] e_op1, e_op2;
    logic [3:0]  e_dst;
  } vec_t;

  logic        clk, reset;
  int          n_chk, n_pass, n;
  logic [63:0] rf [NREGS];
  vec_t        tbl [9];

  alu_issue_if bus ();
  alu_issue dut (.clk(clk), .reset(reset), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    bus.rf_rdata1 = rf[bus.rf_raddr1];
    bus.rf_rdata2 = rf[bus.rf_raddr2];
  end

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= 64'hA0 + 64'(i);
      rf[1] <= 64'd5;
      rf[2] <= 64'd7;
    end else if (bus.wb_valid) begin
      rf[bus.wb_dst] <= bus.wb_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic iv, input opcode_t op, input logic [3:0] d,
                       input logic [3:0] s1, input logic [3:0] s2, input logic ui,
                       input logic [63:0] imm, input logic rdf, input logic wrf);
    bus.in_valid    = iv;
    bus.in_opcode   = op;
    bus.in_dst      = d;
    bus.in_src1     = s1;
    bus.in_src2     = s2;
    bus.in_use_imm  = ui;
    bus.in_imm      = imm;
    bus.in_rd_flags = rdf;
    bus.in_wr_flags = wrf;
  endtask

  task automatic idle();
    drive(1'b0, OP_ADD, 4'd0, 4'd0, 4'd0, 1'b0, 64'd0, 1'b0, 1'b0);
    bus.alu_ready = 1'b1;
    bus.wb_valid  = 1'b0;
    bus.wb_dst    = 4'd0;
    bus.wb_data   = 64'd0;
    bus.wb_flags  = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic wait_issue(output int cycles);
    cycles = 0;
    while (!bus.alu_valid && cycles < 4) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;

    // In-flow, backpressure and drain; rf[5]=A5 rf[6]=A6 rf[8]=A8.
    tbl[0] = '{1'b1, OP_ADD, 4'd3, 4'd1, 4'd2, 1'b0, 64'd0,    1'b1, 1'b1, 1'b0, 64'd0,    64'd0,    4'd0};
    tbl[1] = '{1'b1, OP_SUB, 4'd4, 4'd5, 4'd6, 1'b0, 64'd0,    1'b1, 1'b1, 1'b0, 64'd0,    64'd0,    4'd0};
    tbl[2] = '{1'b1, OP_AND, 4'd7, 4'd8, 4'd0, 1'b1, 64'h55,   1'b0, 1'b0, 1'b1, 64'd5,    64'd7,    4'd3};
    tbl[3] = '{1'b1, OP_AND, 4'd7, 4'd8, 4'd0, 1'b1, 64'h55,   1'b0, 1'b0, 1'b1, 64'd5,    64'd7,    4'd3};
    tbl[4] = '{1'b1, OP_AND, 4'd7, 4'd8, 4'd0, 1'b1, 64'h55,   1'b0, 1'b0, 1'b1, 64'd5,    64'd7,    4'd3};
    tbl[5] = '{1'b1, OP_AND, 4'd7, 4'd8, 4'd0, 1'b1, 64'h55,   1'b1, 1'b1, 1'b1, 64'd5,    64'd7,    4'd3};
    tbl[6] = '{1'b0, OP_ADD, 4'd0, 4'd0, 4'd0, 1'b0, 64'd0,    1'b1, 1'b1, 1'b1, 64'hA5,   64'hA6,   4'd4};
    tbl[7] = '{1'b0, OP_ADD, 4'd0, 4'd0, 4'd0, 1'b0, 64'd0,    1'b1, 1'b1, 1'b1, 64'hA8,   64'h55,   4'd7};
    tbl[8] = '{1'b0, OP_ADD, 4'd0, 4'd0, 4'd0, 1'b0, 64'd0,    1'b1, 1'b1, 1'b0, 64'd0,    64'd0,    4'd0};

    // Reset held with in_valid high.
    idle();
    drive(1'b1, OP_ADD, 4'd3, 4'd1, 4'd2, 1'b0, 64'd0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_alu_valid", 64'(bus.alu_valid), 64'd0);
    chk("rst_busy", 64'(dut.u_sb.busy_q), 64'd0);
    chk("rst_fbusy", 64'(dut.u_sb.fbusy_q), 64'd0);
    chk("rst_operand1", bus.alu_operand1, 64'd0);
    chk("rst_operand2", bus.alu_operand2, 64'd0);
    chk("rst_dst", 64'(bus.alu_dst), 64'd0);
    chk("rst_opcode", 64'(bus.alu_opcode), 64'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    idle();
    tick();

    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].iv, tbl[i].op, tbl[i].dst, tbl[i].s1, tbl[i].s2, tbl[i].ui,
            tbl[i].imm, 1'b0, 1'b0);
      bus.alu_ready = tbl[i].ar;
      #1;
      chk($sformatf("tbl%0d_in_ready", i), 64'(bus.in_ready), 64'(tbl[i].e_ir));
      chk($sformatf("tbl%0d_alu_valid", i), 64'(bus.alu_valid), 64'(tbl[i].e_av));
      if (tbl[i].e_av) begin
        chk($sformatf("tbl%0d_operand1", i), bus.alu_operand1, tbl[i].e_op1);
        chk($sformatf("tbl%0d_operand2", i), bus.alu_operand2, tbl[i].e_op2);
        chk($sformatf("tbl%0d_dst", i), 64'(bus.alu_dst), 64'(tbl[i].e_dst));
      end
      tick();
    end
    chk("tbl_busy", 64'(dut.u_sb.busy_q), 64'h0098);

    // RAW on r3: writeback two cycles after A reaches the ALU port.
    do_reset();
    drive(1'b1, OP_ADD, 4'd3, 4'd1, 4'd2, 1'b0, 64'd0, 1'b0, 1'b0);
    tick();
    drive(1'b1, OP_ADD, 4'd5, 4'd3, 4'd4, 1'b0, 64'd0, 1'b0, 1'b0);
    #1;
    chk("raw_a_move", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("raw_a_valid", 64'(bus.alu_valid), 64'd1);
    chk("raw_a_operand1", bus.alu_operand1, 64'd5);
    chk("raw_a_operand2", bus.alu_operand2, 64'd7);
    chk("raw_b_stall", 64'(bus.in_ready), 64'd0);
    chk("raw_busy3", 64'(dut.u_sb.busy_q[3]), 64'd1);
    tick();
    bus.wb_valid = 1'b1;
    bus.wb_dst   = 4'd3;
    bus.wb_data  = 64'h2A;
    #1;
    chk("raw_wb_cycle_ready", 64'(bus.in_ready), 64'(FWD));
    tick();
    bus.wb_valid = 1'b0;
    wait_issue(n);
    chk("raw_b_latency", 64'(n), FWD ? 64'd0 : 64'd1);
    chk("raw_b_operand1", bus.alu_operand1, 64'h2A);
    chk("raw_b_operand2", bus.alu_operand2, 64'hA4);
    chk("raw_b_dst", 64'(bus.alu_dst), 64'd5);
    chk("raw_busy_after", 64'(dut.u_sb.busy_q), 64'h0020);

    // Flags: CMP writes RFLAGS, following uop reads RFLAGS.
    do_reset();
    drive(1'b1, OP_CMP, 4'd9, 4'd1, 4'd2, 1'b0, 64'd0, 1'b0, 1'b1);
    tick();
    drive(1'b1, OP_ADC, 4'd10, 4'd5, 4'd6, 1'b0, 64'd0, 1'b1, 1'b0);
    #1;
    chk("flg_cmp_move", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("flg_cmp_valid", 64'(bus.alu_valid), 64'd1);
    chk("flg_cmp_wr_flags", 64'(bus.alu_wr_flags), 64'd1);
    chk("flg_cmp_opcode", 64'(bus.alu_opcode), 64'(OP_CMP));
    chk("flg_stall", 64'(bus.in_ready), 64'd0);
    chk("flg_fbusy", 64'(dut.u_sb.fbusy_q), 64'd1);
    tick();
    bus.wb_valid = 1'b1;
    bus.wb_dst   = 4'd9;
    bus.wb_data  = 64'h11;
    bus.wb_flags = 1'b0;
    #1;
    chk("flg_stall_noflags", 64'(bus.in_ready), 64'd0);
    tick();
    chk("flg_busy_cleared", 64'(dut.u_sb.busy_q), 64'd0);
    bus.wb_dst   = 4'd0;
    bus.wb_data  = 64'h77;
    bus.wb_flags = 1'b1;
    #1;
    chk("flg_wb_cycle_ready", 64'(bus.in_ready), 64'(FWD));
    tick();
    bus.wb_valid = 1'b0;
    bus.wb_flags = 1'b0;
    chk("flg_fbusy_cleared", 64'(dut.u_sb.fbusy_q), 64'd0);
    chk("flg_nonbusy_wb", 64'(dut.u_sb.busy_q[0]), 64'd0);
    wait_issue(n);
    chk("flg_latency", 64'(n), FWD ? 64'd0 : 64'd1);
    chk("flg_j_wr_flags", 64'(bus.alu_wr_flags), 64'd0);
    chk("flg_j_operand1", bus.alu_operand1, 64'hA5);
    chk("flg_j_dst", 64'(bus.alu_dst), 64'd10);

    // Issue of dst=4 coincides with a writeback to r4, then async reset mid-stall.
    do_reset();
    drive(1'b1, OP_ADD, 4'd4, 4'd1, 4'd2, 1'b0, 64'd0, 1'b0, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    bus.wb_valid = 1'b1;
    bus.wb_dst   = 4'd4;
    bus.wb_data  = 64'h99;
    #1;
    chk("sw_move", 64'(bus.in_ready), 64'd1);
    tick();
    bus.wb_valid = 1'b0;
    chk("sw_busy4", 64'(dut.u_sb.busy_q[4]), 64'd1);
    bus.alu_ready = 1'b0;
    drive(1'b1, OP_SUB, 4'd6, 4'd4, 4'd1, 1'b0, 64'd0, 1'b0, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("sw_r_stall", 64'(bus.in_ready), 64'd0);
    chk("sw_out_held", 64'(bus.alu_valid), 64'd1);
    chk("sw_raddr1", 64'(bus.rf_raddr1), 64'd4);
    reset = 1'b1;
    #1;
    chk("mid_rst_alu_valid", 64'(bus.alu_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("mid_rst_busy", 64'(dut.u_sb.busy_q), 64'd0);
    chk("mid_rst_operand1", bus.alu_operand1, 64'd0);
    chk("mid_rst_raddr1", 64'(bus.rf_raddr1), 64'd0);
    tick();
    reset = 1'b0;
    bus.alu_ready = 1'b1;
    #1;
    chk("mid_rst_ready_after", 64'(bus.in_ready), 64'd1);
    tick();
    chk("mid_rst_no_stale", 64'(bus.alu_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
